ten_meter_pulse_gen: RTL and testbench

Conditions the raw wheel-rotation sensor and produces the `ten_meter_pulse` and `wait_en` signals consumed by the distance/fare counter. It synchronizes and debounces the sensor, divides wheel ticks by a programmable ticks-per-10 m ratio, and stretches each result into a clean, minimum-width pulse. It also flags a stopped or crawling vehicle so that waiting time is billed instead of distance. It is the producer end of the distance-pulse interface: it sits between the vehicle sensor pin and the fare datapath, on the system clock.

---
 rtl/ten_meter_pulse_gen_if.sv | 20 ++
 rtl/ten_meter_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_ten_meter_pulse_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ten_meter_pulse_gen_if.sv
// Distance-pulse interface between the wheel-sensor conditioner and the fare datapath.
// The master end is the pulse generator; the slave end drives enable, sensor and ratio.
interface ten_meter_pulse_gen_if;
    logic       en;
    logic       hall_in;
    logic [7:0] ticks_per_10m;
    logic       ten_meter_pulse;
    logic       wait_en;
    logic       overflow;

    modport master (
        input  en, hall_in, ticks_per_10m,
        output ten_meter_pulse, wait_en, overflow
    );

    modport slave (
        output en, hall_in, ticks_per_10m,
        input  ten_meter_pulse, wait_en, overflow
    );
endinterface

// File: rtl/ten_meter_pulse_gen.sv
// Wheel sensor conditioning: sync, debounce, divide by ticks-per-10m, stretch into
// fixed-width distance pulses, and flag an idle wheel so waiting time is billed.
//
// state | meaning
// IDLE  | no pulse in flight
// HIGH  | ten_meter_pulse driven high for PULSE_CYCLES clocks
// GAP   | enforced low gap of PULSE_CYCLES clocks before the next pulse
module ten_meter_pulse_gen #(
    parameter int DEBOUNCE_CYCLES     = 16,
    parameter int PULSE_CYCLES        = 4,
    parameter int WAIT_TIMEOUT_CYCLES = 50_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    ten_meter_pulse_gen_if.master bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int TW = $clog2(WAIT_TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(1);
    localparam logic [TW-1:0] WAIT_MAX   = TW'(WAIT_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(WAIT_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    logic [1:0]    sync;
    logic          hall_f;
    logic          hall_f_d;
    logic [DW-1:0] deb_cnt;
    logic          wheel_tick;
    logic [7:0]    div_cnt;
    logic [7:0]    div_last;
    logic          launch;
    state_t        state;
    logic [PW-1:0] width_cnt;
    logic          pending;
    logic          pulse_q;
    logic          overflow_q;
    logic          gap_done;
    logic [TW-1:0] idle_timer;
    logic          wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= '0;
            hall_f     <= 1'b0;
            hall_f_d   <= 1'b0;
            deb_cnt    <= '0;
            wheel_tick <= 1'b0;
        end else begin
            sync     <= {sync[0], bus.hall_in};
            hall_f_d <= hall_f;
            wheel_tick <= hall_f & ~hall_f_d;
            if (sync[1] == hall_f) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                hall_f  <= ~hall_f;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // A ratio of 0 behaves as 1; the >= compare keeps a lowered ratio from wrapping.
    assign div_last = (bus.ticks_per_10m == 8'd0) ? 8'd0 : bus.ticks_per_10m - 8'd1;
    assign launch   = wheel_tick & bus.en & (div_cnt >= div_last);
    assign gap_done = (state == GAP) && (width_cnt == PULSE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!bus.en) begin
            div_cnt <= '0;
        end else if (wheel_tick) begin
            div_cnt <= (div_cnt >= div_last) ? 8'd0 : div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            width_cnt  <= '0;
            pulse_q    <= 1'b0;
            pending    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= HIGH;
                        width_cnt <= PULSE_LOAD;
                        pulse_q   <= 1'b1;
                    end
                end
                HIGH: begin
                    if (width_cnt == PULSE_LAST) begin
                        state     <= GAP;
                        width_cnt <= PULSE_LOAD;
                        pulse_q   <= 1'b0;
                    end else begin
                        width_cnt <= width_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (width_cnt == PULSE_LAST) begin
                        if (pending || launch) begin
                            state     <= HIGH;
                            width_cnt <= PULSE_LOAD;
                            pulse_q   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        width_cnt <= width_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pulse_q <= 1'b0;
                end
            endcase

            // An event landing on the consume cycle takes the freed slot.
            if (!bus.en) begin
                pending <= 1'b0;
            end else if (gap_done) begin
                pending <= pending & launch;
            end else if (launch && state != IDLE) begin
                if (pending) begin
                    overflow_q <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_timer <= '0;
            wait_q     <= 1'b0;
        end else if (!bus.en || wheel_tick) begin
            idle_timer <= '0;
            wait_q     <= 1'b0;
        end else if (idle_timer != WAIT_MAX) begin
            idle_timer <= idle_timer + 1'b1;
            wait_q     <= (idle_timer == WAIT_LAST);
        end else begin
            wait_q <= 1'b1;
        end
    end

    assign bus.ten_meter_pulse = pulse_q;
    assign bus.wait_en         = wait_q;
    assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_ten_meter_pulse_gen.sv
// Directed bench for ten_meter_pulse_gen: a main instance (debounce 4, pulse 2, wait 50)
// and a fast instance (debounce 1, pulse 4) that can outrun the pulse stretcher.
module tb_ten_meter_pulse_gen;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    ten_meter_pulse_gen_if bus_a ();
    ten_meter_pulse_gen_if bus_b ();

    ten_meter_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .WAIT_TIMEOUT_CYCLES(50)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    ten_meter_pulse_gen #(
        .DEBOUNCE_CYCLES(1), .PULSE_CYCLES(4), .WAIT_TIMEOUT_CYCLES(50)
    ) u_fast (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Main instance: count pulses and check every completed pulse is 2 clocks wide.
    int   pulses_a = 0;
    int   width_a  = 0;
    logic prev_a   = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a  = 1'b0;
            width_a = 0;
        end else begin
            if (bus_a.ten_meter_pulse) begin
                if (!prev_a) pulses_a++;
                width_a++;
            end else if (prev_a) begin
                check("pulse_width", width_a, 2);
                width_a = 0;
            end
            prev_a = bus_a.ten_meter_pulse;
        end
    end

    int   pulses_b = 0;
    int   rise_b[2];
    logic prev_b   = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_b.ten_meter_pulse && !prev_b) begin
                if (pulses_b < 2) rise_b[pulses_b] = cyc;
                pulses_b++;
            end
            prev_b = bus_b.ten_meter_pulse;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo);
        bus_a.hall_in = 1'b1;
        step(hi);
        bus_a.hall_in = 1'b0;
        step(lo);
    endtask

    int base;

    initial begin
        rst_n               = 1'b0;
        bus_a.en            = 1'b0;
        bus_a.hall_in       = 1'b0;
        bus_a.ticks_per_10m = 8'd0;
        bus_b.en            = 1'b1;
        bus_b.hall_in       = 1'b0;
        bus_b.ticks_per_10m = 8'd1;
        rise_b[0]           = 0;
        rise_b[1]           = 0;
        step(2);
        check("rst_pulse", bus_a.ten_meter_pulse, 0);
        check("rst_wait", bus_a.wait_en, 0);
        check("rst_ovf", bus_a.overflow, 0);
        check("rst_ovf_fast", bus_b.overflow, 0);
        rst_n = 1'b1;
        step(1);

        // Ratio 3: the third hall rise launches, pulse rises 8 clocks after it.
        bus_a.en            = 1'b1;
        bus_a.ticks_per_10m = 8'd3;
        wave(10, 10);
        wave(10, 10);
        bus_a.hall_in = 1'b1;
        step(7);
        check("lat_before", bus_a.ten_meter_pulse, 0);
        step(1);
        check("lat_rise", bus_a.ten_meter_pulse, 1);
        step(2);
        bus_a.hall_in = 1'b0;
        step(10);
        repeat (3) wave(10, 10);
        check("ratio3_pulses", pulses_a, 2);
        check("ratio3_ovf", bus_a.overflow, 0);

        // Glitch and toggle burst must not produce extra ticks.
        bus_a.ticks_per_10m = 8'd1;
        base = pulses_a;
        wave(3, 6);
        wave(1, 1);
        wave(1, 2);
        wave(10, 10);
        check("bounce_pulses", pulses_a - base, 1);

        bus_a.ticks_per_10m = 8'd0;
        base = pulses_a;
        repeat (3) wave(10, 10);
        check("zero_ratio", pulses_a - base, 3);

        bus_a.ticks_per_10m = 8'd5;
        base = pulses_a;
        repeat (3) wave(10, 10);
        check("mid_3ticks", pulses_a - base, 0);
        bus_a.ticks_per_10m = 8'd2;
        wave(10, 10);
        check("mid_4th", pulses_a - base, 1);
        wave(10, 10);
        check("mid_5th", pulses_a - base, 1);
        wave(10, 10);
        check("mid_6th", pulses_a - base, 2);

        // Fast instance: ticks every 2 clocks against an 8-clock pulse period.
        repeat (3) begin
            bus_b.hall_in = 1'b1;
            step(1);
            bus_b.hall_in = 1'b0;
            step(1);
        end
        step(30);
        check("fast_pulses", pulses_b, 2);
        check("fast_spacing", rise_b[1] - rise_b[0], 8);
        check("fast_ovf", bus_b.overflow, 1);
        step(20);
        check("fast_ovf_sticky", bus_b.overflow, 1);

        bus_a.ticks_per_10m = 8'd3;
        wave(10, 10);
        check("div_one", u_dut.div_cnt, 1);
        bus_a.en = 1'b0;
        step(1);
        check("div_en_low", u_dut.div_cnt, 0);
        bus_a.ticks_per_10m = 8'd1;
        base = pulses_a;
        wave(10, 10);
        check("en_low_no_event", pulses_a - base, 0);

        bus_a.en = 1'b1;
        step(49);
        check("wait_49", bus_a.wait_en, 0);
        step(1);
        check("wait_50", bus_a.wait_en, 1);
        bus_a.hall_in = 1'b1;
        step(7);
        check("wait_at_tick", bus_a.wait_en, 1);
        step(1);
        check("wait_fall", bus_a.wait_en, 0);
        check("en_pulse_rise", bus_a.ten_meter_pulse, 1);
        bus_a.en = 1'b0;
        step(1);
        check("en_low_pulse_hold", bus_a.ten_meter_pulse, 1);
        step(1);
        check("en_low_pulse_end", bus_a.ten_meter_pulse, 0);
        check("en_low_wait", bus_a.wait_en, 0);
        bus_a.hall_in = 1'b0;
        step(10);

        bus_a.en      = 1'b1;
        bus_a.hall_in = 1'b1;
        step(8);
        check("pre_rst_pulse", bus_a.ten_meter_pulse, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_pulse", bus_a.ten_meter_pulse, 0);
        check("rst_mid_wait", bus_a.wait_en, 0);
        check("rst_mid_ovf", bus_a.overflow, 0);
        check("rst_clears_ovf", bus_b.overflow, 0);
        step(2);
        bus_a.hall_in = 1'b0;
        rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
